// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, multi-cycle
// results queue in a FIFO. Optional starvation stall: WB_ARB_STARVE_EN.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  wb_wd,
    input  logic        wb_wreg,
    input  logic [31:0] wb_wdata,
    input  logic        mc_valid,
    input  logic [4:0]  mc_wd,
    input  logic [31:0] mc_wdata,
    output logic        mc_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    output logic        mc_pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [36:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic          pipe_wr, push, pop;
    logic [36:0]   head;

    assign mc_ready   = (count_q < CW'(DEPTH));
    assign mc_pending = (count_q != '0);
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign head       = mem_q[rd_ptr_q];

    // Grant, FIFO bookkeeping and next write-port values
    always_comb begin
        pipe_wr  = wb_wreg && (wb_wd != 5'd0);
        push     = mc_valid && mc_ready && (mc_wd != 5'd0);
        pop      = !pipe_wr && mc_pending;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        rf_we_d    = pipe_wr || pop;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pipe_wr) begin
            rf_waddr_d = wb_wd;
            rf_wdata_d = wb_wdata;
        end else if (pop) begin
            rf_waddr_d = head[36:32];
            rf_wdata_d = head[31:0];
        end
    end

    // FIFO storage, pointers and registered write port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {mc_wd, mc_wdata};
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef WB_ARB_STARVE_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STALL
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic       stall_req_q, stall_req_d;

    // Starvation state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            stall_req_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            stall_req_q  <= stall_req_d;
        end
    end

    // Next state: count cycles a buffered result loses to the pipeline
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (count_d != '0) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pop) begin
                    starve_cnt_d = '0;
                    if (count_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end else if (pipe_wr) begin
                    if (starve_cnt_q < LIMIT) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                    if (starve_cnt_d == LIMIT) begin
                        state_d = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (pop) begin
                    starve_cnt_d = '0;
                    state_d = (count_d != '0) ? ST_WAIT : ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                starve_cnt_d = '0;
            end
        endcase
    end

    // Stall request is a registered decode of the next state
    always_comb begin
        stall_req_d = (state_d == ST_STALL);
    end

    assign stall_req = stall_req_q;
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter; queue-based reference
// model predicts write-port traffic, FIFO occupancy and stall requests.
module tb_wb_port_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  wb_wd = '0;
    logic        wb_wreg = 1'b0;
    logic [31:0] wb_wdata = '0;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_wd = '0;
    logic [31:0] mc_wdata = '0;
    logic        mc_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic        mc_pending;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .mc_valid(mc_valid), .mc_wd(mc_wd), .mc_wdata(mc_wdata),
        .mc_ready(mc_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .stall_req(stall_req),
        .mc_pending(mc_pending)
    );

    always #5 clock = ~clock;

    typedef logic [36:0] wr_t;

    wr_t         exp_q[$];
    wr_t         fifo_m[$];
    int          lost_m = 0;
    bit          stall_m = 1'b0;
    logic [4:0]  last_a = '0;
    logic [31:0] last_d = '0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          done = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t",
                      name, act, exp, $time);
    endtask

    // One cycle: check registered-state outputs, drive, advance model
    task automatic cycle(input bit wreg, input logic [4:0] wd,
                         input logic [31:0] wdat, input bit mv,
                         input logic [4:0] mwd, input logic [31:0] mdat,
                         output bit acc);
        bit pipe, rdy, ne, popped;
        @(negedge clock);
        check("mc_ready", 32'(mc_ready), 32'(fifo_m.size() < DEPTH));
        check("mc_pending", 32'(mc_pending), 32'(fifo_m.size() != 0));
        check("stall_req", 32'(stall_req), 32'(stall_m));
        wb_wreg  = wreg;
        wb_wd    = wd;
        wb_wdata = wdat;
        mc_valid = mv;
        mc_wd    = mwd;
        mc_wdata = mdat;
        pipe   = wreg && (wd != 0);
        rdy    = fifo_m.size() < DEPTH;
        ne     = fifo_m.size() != 0;
        popped = 1'b0;
        acc    = mv && rdy;
        if (pipe) exp_q.push_back({wd, wdat});
        else if (ne) begin
            exp_q.push_back(fifo_m.pop_front());
            popped = 1'b1;
        end
        if (acc && mwd != 0) fifo_m.push_back({mwd, mdat});
`ifdef WB_ARB_STARVE_EN
        if (popped) begin
            lost_m  = 0;
            stall_m = 1'b0;
        end else if (ne && pipe) begin
            if (lost_m < LIMIT) lost_m++;
            if (lost_m == LIMIT) stall_m = 1'b1;
        end
`endif
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        wb_wreg  = 1'b0;
        mc_valid = 1'b0;
        fifo_m.delete();
        exp_q.delete();
        lost_m  = 0;
        stall_m = 1'b0;
        last_a  = '0;
        last_d  = '0;
        #1;
        check("rst rf_we", 32'(rf_we), 32'd0);
        check("rst rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst rf_wdata", rf_wdata, 32'd0);
        check("rst mc_ready", 32'(mc_ready), 32'd1);
        check("rst mc_pending", 32'(mc_pending), 32'd0);
        check("rst stall_req", 32'(stall_req), 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: every write-port event must match the oldest prediction
    always @(posedge clock) begin
        #1;
        if (!done) begin
            if (rf_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected rf_we", 32'(rf_we), 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("rf_waddr", 32'(rf_waddr), 32'(e[36:32]));
                    check("rf_wdata", rf_wdata, e[31:0]);
                    last_a = e[36:32];
                    last_d = e[31:0];
                end
            end else begin
                check("hold rf_waddr", 32'(rf_waddr), 32'(last_a));
                check("hold rf_wdata", rf_wdata, last_d);
            end
        end
    end

    initial begin
        bit acc;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        // fill three entries, then reset mid-operation
        for (int i = 1; i <= 3; i++)
            cycle(1, 5'd9, 32'(i), 1, 5'(i + 10), 32'(i * 3), acc);
        do_reset();
        // pipeline write and multi-cycle result together
        cycle(1, 5'd5, 32'hDEADBEEF, 1, 5'd7, 32'h12, acc);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);
        // fill FIFO behind a busy pipeline, hold the 5th result
        for (int i = 1; i <= 4; i++)
            cycle(1, 5'd20, 32'(100 + i), 1, 5'(i), 32'(i * 16), acc);
        for (int i = 0; i < 3; i++)
            cycle(1, 5'd21, 32'(200 + i), 1, 5'd5, 32'h55, acc);
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++)
            cycle(0, 5'd0, 32'd0, 1, 5'd5, 32'h55, acc);
        repeat (6) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);
        // destination r0 from either source
        cycle(0, 5'd0, 32'd0, 1, 5'd0, 32'hFF, acc);
        cycle(1, 5'd3, 32'h33, 1, 5'd6, 32'h66, acc);
        cycle(1, 5'd0, 32'h77, 0, 5'd0, 32'd0, acc);
        repeat (2) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);
        // starvation: one entry, pipeline busy, then idle
        cycle(1, 5'd8, 32'h80, 1, 5'd9, 32'h99, acc);
        for (int i = 0; i < LIMIT + 2; i++)
            cycle(1, 5'd8, 32'(i), 0, 5'd0, 32'd0, acc);
        repeat (3) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);
        cycle(1, 5'd8, 32'h81, 1, 5'd10, 32'hAA, acc);
        for (int i = 0; i < 50; i++)
            cycle(1, 5'd8, 32'(i), 0, 5'd0, 32'd0, acc);
        repeat (3) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);
        // randomized traffic with varying pipeline load
        for (int ph = 0; ph < 6; ph++) begin
            int pp;
            pp = 30 + ph * 12;
            for (int i = 0; i < 500; i++) begin
                bit wr, mv;
                logic [4:0] wd, mwd;
                wr  = ($urandom_range(0, 99) < pp);
                mv  = ($urandom_range(0, 99) < 50);
                wd  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
                mwd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
                if ($urandom_range(0, 599) == 0) do_reset();
                cycle(wr, wd, $urandom, mv, mwd, $urandom, acc);
            end
        end
        repeat (8) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, acc);
        @(negedge clock);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the pipeline writeback stage (MEM/WB register outputs) and a multi-cycle execution unit (divider/multiplier result path). Pipeline writes always win; multi-cycle results are buffered in a small FIFO and drained into idle write-port cycles. A starvation counter can request a pipeline stall so buffered results cannot wait forever. Sits between the MEM/WB register, the multi-cycle unit and the register file.

## Interface
Parameters:
- DEPTH, 4, FIFO entries for multi-cycle results; power of two, 2..16.
- STARVE_LIMIT, 8, consecutive lost cycles before stall_req asserts; 1..255.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wb_wd  in  5  pipeline destination register.
- wb_wreg  in  1  pipeline write enable.
- wb_wdata  in  32  pipeline write data.
- mc_valid  in  1  multi-cycle result valid.
- mc_wd  in  5  multi-cycle destination register.
- mc_wdata  in  32  multi-cycle result data.
- mc_ready  out  1  FIFO can accept; combinational from registered count.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  5  register-file write address, registered.
- rf_wdata  out  32  register-file write data, registered.
- stall_req  out  1  request to pipeline controller to insert bubbles, registered.
- mc_pending  out  1  FIFO non-empty (count != 0), registered-state decode.

## Operation
- pipe_wr = wb_wreg && (wb_wd != 0). Writes to register 0 from either source are discarded (not driven on rf_we, never pushed).
- mc_ready = (count < DEPTH). Push when mc_valid && mc_ready && mc_wd != 0; mc_valid && mc_wd == 0 is accepted (handshake completes) but not stored.
- Full FIFO: mc_ready = 0 even if a pop occurs that cycle (no same-cycle refill when full).
- Grant each cycle: pipe_wr → pipeline write selected; else if FIFO non-empty → head popped and selected; else no write.
- Push and pop in the same cycle allowed when count < DEPTH; count unchanged. Push into empty FIFO is not bypassed: the entry cannot be popped in the cycle it is pushed.
- FIFO is in-order; read/write pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
- Issue logic guarantees no outstanding multi-cycle destination is written by the pipeline; block does no address ordering checks.
- Starvation FSM, states IDLE / WAIT / STALL:
  - IDLE: FIFO empty. → WAIT when count becomes non-zero.
  - WAIT: starve_cnt increments each cycle FIFO non-empty and pipe_wr wins; cleared on any pop. → STALL when starve_cnt reaches STARVE_LIMIT; → IDLE when FIFO becomes empty.
  - STALL: stall_req = 1. Pipeline writes still take priority (in-flight instructions never dropped). On a pop: → WAIT (cnt cleared) if FIFO still non-empty, else IDLE.
- starve_cnt saturates at STARVE_LIMIT.

## Timing
- Reset values: rf_we 0, rf_waddr 0, rf_wdata 0, stall_req 0, mc_pending 0, mc_ready 1, count 0, pointers 0, starve_cnt 0, FSM IDLE.
- Reset mid-operation discards all buffered entries immediately (asynchronous).
- Pipeline write latency: rf_* reflect wb_* one cycle after the cycle pipe_wr is sampled.
- Multi-cycle latency: earliest rf_we for an accepted result is 2 cycles after the handshake edge (push edge, then pop edge).
- stall_req asserts on the edge where starve_cnt reaches STARVE_LIMIT; deasserts on the edge of the pop.
- When rf_we = 0, rf_waddr/rf_wdata hold their previous values.

## Configuration
- WB_ARB_STARVE_EN defined: starve_cnt, FSM and stall_req logic compiled in as above.
- Not defined: no counter or FSM; stall_req tied to 0; FIFO drains only on idle pipeline cycles; all other behaviour identical.

## Test plan
- Reset with FIFO holding 3 entries → after release count 0, mc_ready 1, mc_pending 0, rf_we 0.
- wb_wreg=1, wb_wd=5, wb_wdata=0xDEADBEEF with mc_valid=1, mc_wd=7, mc_wdata=0x12 → cycle+1 rf writes r5=0xDEADBEEF; first idle cycle pops r7=0x12 one cycle later.
- Push 4 results (r1..r4) while pipeline writes every cycle → mc_ready 0 after 4th; 5th mc_valid held; on idle cycles r1,r2,r3,r4 written in order; mc_ready reasserts the cycle after first pop.
- mc_wd=0, mc_wdata=0xFF with pipeline idle → handshake completes, count stays 0, no rf_we; wb_wd=0 with wb_wreg=1 → no rf_we and FIFO head pops instead.
- STARVE_LIMIT=8, one buffered entry, pipeline writes 8 consecutive cycles → stall_req=1 on 8th edge; first pipeline-idle cycle pops entry, stall_req=0 next edge, FSM IDLE.
- Without WB_ARB_STARVE_EN, same stimulus for 50 cycles → stall_req stays 0, entry remains, mc_pending 1.
